collapse_bank_host_if: RTL and testbench

Command sequencer that sits directly upstream of collapse_bank. It accepts host INIT/READ commands over a valid/ready handshake and drives the bank's init and read strobes as single-cycle pulses. It captures the bank's read data after a fixed latency and returns one response per command. It keeps a per-address armed bitmap so read-once semantics are enforced and reported at the host boundary.

---
 rtl/collapse_bank_host_if.sv | 228 ++++++++++++++++++++++
 tb/tb_collapse_bank_host_if.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/collapse_bank_host_if.sv
// Host command sequencer for collapse_bank: INIT/READ with read-once tracking.
// Optional CBH_STATS_EN adds saturating init/read/error counters.
module collapse_bank_host_if #(
    parameter int N       = 1024,
    parameter int DATA_W  = 8,
    parameter int BASIS_W = 8,
    parameter int ADDR_W  = $clog2(N),
    parameter int RD_LAT  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_op,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [DATA_W-1:0]  cmd_value,
    input  logic [BASIS_W-1:0] cmd_basis,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_data,
    output logic [1:0]         rsp_status,
    output logic [ADDR_W-1:0]  bank_init_addr,
    output logic [DATA_W-1:0]  bank_init_value,
    output logic [BASIS_W-1:0] bank_init_basis,
    output logic               bank_init_strobe,
    output logic [ADDR_W-1:0]  bank_read_addr,
    output logic [BASIS_W-1:0] bank_basis,
    output logic               bank_read_pulse,
    input  logic [DATA_W-1:0]  bank_data_i
`ifdef CBH_STATS_EN
    ,
    output logic [15:0]        stat_inits,
    output logic [15:0]        stat_reads,
    output logic [15:0]        stat_errors
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [1:0] ST_OK        = 2'b00;
    localparam logic [1:0] ST_NOT_ARMED = 2'b01;
    localparam logic [1:0] ST_OVERWRITE = 2'b10;

    localparam logic [ADDR_W:0] N_LIM   = (ADDR_W+1)'(N);
    localparam logic [2:0]      LAT_INI = 3'(RD_LAT);

    logic [1:0]         state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [N-1:0]       armed_q, armed_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic [1:0]         rsp_status_q, rsp_status_d;
    logic [ADDR_W-1:0]  init_addr_q, init_addr_d;
    logic [DATA_W-1:0]  init_value_q, init_value_d;
    logic [BASIS_W-1:0] init_basis_q, init_basis_d;
    logic               init_strobe_q, init_strobe_d;
    logic [ADDR_W-1:0]  read_addr_q, read_addr_d;
    logic [BASIS_W-1:0] read_basis_q, read_basis_d;
    logic               read_pulse_q, read_pulse_d;

    logic addr_ok;
    logic cmd_fire;

    assign addr_ok  = ({1'b0, cmd_addr} < N_LIM);
    assign cmd_fire = cmd_valid && cmd_ready_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        armed_d       = armed_q;
        cmd_ready_d   = cmd_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_status_d  = rsp_status_q;
        init_addr_d   = init_addr_q;
        init_value_d  = init_value_q;
        init_basis_d  = init_basis_q;
        init_strobe_d = 1'b0;
        read_addr_d   = read_addr_q;
        read_basis_d  = read_basis_q;
        read_pulse_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_fire) begin
                    cmd_ready_d = 1'b0;
                    if (!cmd_op && addr_ok) begin
                        init_addr_d   = cmd_addr;
                        init_value_d  = cmd_value;
                        init_basis_d  = cmd_basis;
                        init_strobe_d = 1'b1;
                        state_d       = S_ISSUE;
                    end else if (cmd_op && addr_ok && armed_q[cmd_addr]) begin
                        read_addr_d  = cmd_addr;
                        read_basis_d = cmd_basis;
                        read_pulse_d = 1'b1;
                        state_d      = S_ISSUE;
                    end else begin
                        // unarmed read or out-of-range init: no bank activity
                        rsp_valid_d  = 1'b1;
                        rsp_data_d   = '0;
                        rsp_status_d = ST_NOT_ARMED;
                        state_d      = S_RESP;
                    end
                end
            end
            S_ISSUE: begin
                if (init_strobe_q) begin
                    rsp_status_d = armed_q[init_addr_q] ? ST_OVERWRITE
                                                        : ST_OK;
                    armed_d[init_addr_q] = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    state_d     = S_RESP;
                end else begin
                    armed_d[read_addr_q] = 1'b0;
                    cnt_d   = LAT_INI;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q <= 3'd1) begin
                    rsp_valid_d  = 1'b1;
                    rsp_data_d   = bank_data_i;
                    rsp_status_d = ST_OK;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            armed_q       <= '0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_status_q  <= '0;
            init_addr_q   <= '0;
            init_value_q  <= '0;
            init_basis_q  <= '0;
            init_strobe_q <= 1'b0;
            read_addr_q   <= '0;
            read_basis_q  <= '0;
            read_pulse_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            armed_q       <= armed_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_status_q  <= rsp_status_d;
            init_addr_q   <= init_addr_d;
            init_value_q  <= init_value_d;
            init_basis_q  <= init_basis_d;
            init_strobe_q <= init_strobe_d;
            read_addr_q   <= read_addr_d;
            read_basis_q  <= read_basis_d;
            read_pulse_q  <= read_pulse_d;
        end
    end

    assign cmd_ready        = cmd_ready_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_data         = rsp_data_q;
    assign rsp_status       = rsp_status_q;
    assign bank_init_addr   = init_addr_q;
    assign bank_init_value  = init_value_q;
    assign bank_init_basis  = init_basis_q;
    assign bank_init_strobe = init_strobe_q;
    assign bank_read_addr   = read_addr_q;
    assign bank_basis       = read_basis_q;
    assign bank_read_pulse  = read_pulse_q;

`ifdef CBH_STATS_EN
    logic [15:0] inits_q, inits_d;
    logic [15:0] reads_q, reads_d;
    logic [15:0] errors_q, errors_d;
    logic        err_evt;

    // an error is counted once, on the cycle its response is produced
    assign err_evt = rsp_valid_d && !rsp_valid_q && (rsp_status_d != ST_OK);

    always_comb begin
        inits_d  = inits_q;
        reads_d  = reads_q;
        errors_d = errors_q;
        if (init_strobe_q && inits_q != 16'hFFFF) inits_d = inits_q + 16'd1;
        if (read_pulse_q && reads_q != 16'hFFFF) reads_d = reads_q + 16'd1;
        if (err_evt && errors_q != 16'hFFFF) errors_d = errors_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inits_q  <= '0;
            reads_q  <= '0;
            errors_q <= '0;
        end else begin
            inits_q  <= inits_d;
            reads_q  <= reads_d;
            errors_q <= errors_d;
        end
    end

    assign stat_inits  = inits_q;
    assign stat_reads  = reads_q;
    assign stat_errors = errors_q;
`endif

endmodule

// File: tb/tb_collapse_bank_host_if.sv
// Directed bench for collapse_bank_host_if: RD_LAT=1 instance for the
// command flow, RD_LAT=4 instance for reset during WAIT.
module tb_collapse_bank_host_if;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- instance A: RD_LAT = 1 ----------------
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0, cmd_ready, cmd_op = 1'b0;
    logic [9:0] cmd_addr = '0;
    logic [7:0] cmd_value = '0, cmd_basis = '0;
    logic       rsp_valid, rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic [1:0] rsp_status;
    logic [9:0] init_addr, read_addr;
    logic [7:0] init_value, init_basis, basis, bank_data;
    logic       init_strobe, read_pulse;
`ifdef CBH_STATS_EN
    logic [15:0] sa_i, sa_r, sa_e;
`endif

    collapse_bank_host_if #(.N(1024), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_value(cmd_value), .cmd_basis(cmd_basis),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_status(rsp_status),
        .bank_init_addr(init_addr), .bank_init_value(init_value),
        .bank_init_basis(init_basis), .bank_init_strobe(init_strobe),
        .bank_read_addr(read_addr), .bank_basis(basis),
        .bank_read_pulse(read_pulse), .bank_data_i(bank_data)
`ifdef CBH_STATS_EN
        , .stat_inits(sa_i), .stat_reads(sa_r), .stat_errors(sa_e)
`endif
    );

    // bank model: data valid only RD_LAT cycles after the pulse cycle
    logic [7:0] mem_a [0:1023];
    logic [3:0] dly_a = '0;
    always @(posedge clk) begin
        if (init_strobe) mem_a[init_addr] <= init_value;
        dly_a <= {dly_a[2:0], read_pulse};
    end
    assign bank_data = dly_a[0] ? mem_a[read_addr] : 8'hEE;

    int n_init = 0, n_read = 0;
    always @(negedge clk) begin
        if (init_strobe) n_init++;
        if (read_pulse) n_read++;
    end

    logic       c1_init, c1_read;
    logic [9:0] c1_iaddr, c2_raddr;
    logic [7:0] c2_basis;

    task automatic send(input logic op, input logic [9:0] addr,
                        input logic [7:0] val, input logic [7:0] bs,
                        input int hold, input logic poke,
                        output int lat, output logic [7:0] data,
                        output logic [1:0] st, output logic stable);
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr;
        cmd_value = val; cmd_basis = bs;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        c1_init = init_strobe; c1_read = read_pulse; c1_iaddr = init_addr;
        c2_raddr = '0; c2_basis = '0;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 2) begin
                c2_raddr = read_addr;
                c2_basis = basis;
            end
        end
        data = rsp_data; st = rsp_status; stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                cmd_valid = 1'b1; cmd_op = 1'b0; cmd_addr = 10'd20;
            end
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== data ||
                rsp_status !== st || cmd_ready !== 1'b0) stable = 1'b0;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rdy_back", cmd_ready, 1);
    endtask

    // ---------------- instance B: RD_LAT = 4 ----------------
    logic       rst_b = 1'b1;
    logic       b_cmd_valid = 1'b0, b_cmd_ready, b_cmd_op = 1'b0;
    logic [9:0] b_cmd_addr = '0;
    logic [7:0] b_cmd_value = '0, b_cmd_basis = '0;
    logic       b_rsp_valid, b_rsp_ready = 1'b0;
    logic [7:0] b_rsp_data;
    logic [1:0] b_rsp_status;
    logic [9:0] b_init_addr, b_read_addr;
    logic [7:0] b_init_value, b_init_basis, b_basis, b_bank_data;
    logic       b_init_strobe, b_read_pulse;
`ifdef CBH_STATS_EN
    logic [15:0] sb_i, sb_r, sb_e;
`endif

    collapse_bank_host_if #(.N(1024), .RD_LAT(4)) dut_b (
        .clk(clk), .rst(rst_b),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_op(b_cmd_op),
        .cmd_addr(b_cmd_addr), .cmd_value(b_cmd_value),
        .cmd_basis(b_cmd_basis),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_data(b_rsp_data), .rsp_status(b_rsp_status),
        .bank_init_addr(b_init_addr), .bank_init_value(b_init_value),
        .bank_init_basis(b_init_basis), .bank_init_strobe(b_init_strobe),
        .bank_read_addr(b_read_addr), .bank_basis(b_basis),
        .bank_read_pulse(b_read_pulse), .bank_data_i(b_bank_data)
`ifdef CBH_STATS_EN
        , .stat_inits(sb_i), .stat_reads(sb_r), .stat_errors(sb_e)
`endif
    );

    logic [7:0] mem_b [0:1023];
    logic [3:0] dly_b = '0;
    always @(posedge clk) begin
        if (b_init_strobe) mem_b[b_init_addr] <= b_init_value;
        dly_b <= {dly_b[2:0], b_read_pulse};
    end
    assign b_bank_data = dly_b[3] ? mem_b[b_read_addr] : 8'hEE;

    logic b_c1_read;

    task automatic b_issue(input logic op, input logic [9:0] addr,
                           input logic [7:0] val);
        int n;
        n = 0;
        while (!b_cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        b_cmd_valid = 1'b1; b_cmd_op = op; b_cmd_addr = addr;
        b_cmd_value = val; b_cmd_basis = 8'h44;
        @(negedge clk);
        b_cmd_valid = 1'b0;
        b_c1_read = b_read_pulse;
    endtask

    task automatic b_finish(output int lat, output logic [1:0] st);
        lat = 1;
        while (!b_rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        st = b_rsp_status;
        b_rsp_ready = 1'b1;
        @(negedge clk);
        b_rsp_ready = 1'b0;
    endtask

    // ---------------- sequence ----------------
    int         lat, i0, r0, seen;
    logic [7:0] d;
    logic [1:0] st;
    logic       stb;

    initial begin
        #1;
        check("rst_out", {cmd_ready, rsp_valid, rsp_data, rsp_status,
                          init_strobe, read_pulse, init_addr,
                          read_addr}, 0);
        @(negedge clk);
        @(negedge clk);
        check("rst_rdy", cmd_ready, 0);
        rst = 1'b0;
        rst_b = 1'b0;

        i0 = n_init; r0 = n_read;
        send(1'b0, 10'd5, 8'h3C, 8'h11, 0, 1'b0, lat, d, st, stb);
        check("init_lat", lat, 2);
        check("init_st", st, 2'b00);
        check("init_data", d, 8'h00);
        check("init_c1_strobe", c1_init, 1);
        check("init_c1_pulse", c1_read, 0);
        check("init_c1_addr", c1_iaddr, 10'd5);
        check("init_cnt", n_init - i0, 1);

        r0 = n_read;
        send(1'b1, 10'd5, 8'h00, 8'h11, 0, 1'b0, lat, d, st, stb);
        check("rd_lat", lat, 3);
        check("rd_data", d, 8'h3C);
        check("rd_st", st, 2'b00);
        check("rd_c1_pulse", c1_read, 1);
        check("rd_c2_addr", c2_raddr, 10'd5);
        check("rd_c2_basis", c2_basis, 8'h11);
        check("rd_cnt", n_read - r0, 1);

        r0 = n_read;
        send(1'b1, 10'd5, 8'h00, 8'h11, 0, 1'b0, lat, d, st, stb);
        check("rd2_lat", lat, 1);
        check("rd2_st", st, 2'b01);
        check("rd2_data", d, 8'h00);
        check("rd2_cnt", n_read - r0, 0);

        i0 = n_init;
        send(1'b0, 10'd7, 8'hAA, 8'h22, 0, 1'b0, lat, d, st, stb);
        check("i7a_st", st, 2'b00);
        send(1'b0, 10'd7, 8'hBB, 8'h22, 0, 1'b0, lat, d, st, stb);
        check("i7b_st", st, 2'b10);
        check("i7b_lat", lat, 2);
        check("i7_cnt", n_init - i0, 2);
        send(1'b1, 10'd7, 8'h00, 8'h22, 0, 1'b0, lat, d, st, stb);
        check("r7_st", st, 2'b00);
        check("r7_data", d, 8'hBB);

        send(1'b0, 10'd9, 8'h5A, 8'h01, 0, 1'b0, lat, d, st, stb);
        i0 = n_init;
        send(1'b1, 10'd9, 8'h00, 8'h01, 10, 1'b1, lat, d, st, stb);
        check("hold_data", d, 8'h5A);
        check("hold_st", st, 2'b00);
        check("hold_stable", stb, 1);
        check("hold_ignored", n_init - i0, 0);
        send(1'b1, 10'd20, 8'h00, 8'h00, 0, 1'b0, lat, d, st, stb);
        check("r20_st", st, 2'b01);

        b_issue(1'b0, 10'd3, 8'h77);
        b_finish(lat, st);
        check("b_init_lat", lat, 2);
        check("b_init_st", st, 2'b00);
        b_issue(1'b1, 10'd3, 8'h00);
        check("b_c1_pulse", b_c1_read, 1);
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        check("b_rst_out", {b_cmd_ready, b_rsp_valid, b_rsp_data,
                            b_rsp_status, b_init_strobe, b_read_pulse,
                            b_init_addr, b_init_value, b_init_basis,
                            b_read_addr, b_basis}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (b_rsp_valid) seen++;
        end
        check("b_no_rsp", seen, 0);
        b_issue(1'b1, 10'd3, 8'h00);
        check("b_rd_nopulse", b_c1_read, 0);
        b_finish(lat, st);
        check("b_rd_lat", lat, 1);
        check("b_rd_st", st, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
